// File: rtl/instruction_fetch.sv
// Instruction fetch unit: turns a start strobe and PC into a single request/ready read
// on the instruction-memory bus and reports the fetched word or a fault to decode.
`timescale 1ns/1ps
module instruction_fetch #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    output logic        busy,
    output logic        done,
    output logic [31:0] instr,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    // With the timeout disabled the boundary value is never compared, so any value works.
    localparam logic [CNT_W-1:0] CNT_LAST =
        TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    localparam logic [1:0] CAUSE_NONE       = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'd1;
    localparam logic [1:0] CAUSE_BUS        = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic              mem_req_n;
    logic [31:0]       mem_addr_n;
    logic              done_n;
    logic [31:0]       instr_n;
    logic              fault_n;
    logic [1:0]        cause_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            done        <= 1'b0;
            instr       <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
        end else begin
            state       <= state_n;
            count       <= count_n;
            mem_req     <= mem_req_n;
            mem_addr    <= mem_addr_n;
            done        <= done_n;
            instr       <= instr_n;
            fault       <= fault_n;
            fault_cause <= cause_n;
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        mem_req_n  = mem_req;
        mem_addr_n = mem_addr;
        done_n     = 1'b0;
        instr_n    = instr;
        fault_n    = fault;
        cause_n    = fault_cause;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (pc[1:0] != 2'b00) begin
                        done_n  = 1'b1;
                        fault_n = 1'b1;
                        cause_n = CAUSE_MISALIGNED;
                    end else begin
                        mem_addr_n = pc;
                        mem_req_n  = 1'b1;
                        count_n    = '0;
                        fault_n    = 1'b0;
                        cause_n    = CAUSE_NONE;
                        state_n    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A completion on the boundary cycle takes priority over the timeout.
                if (mem_ready) begin
                    done_n    = 1'b1;
                    mem_req_n = 1'b0;
                    state_n   = S_IDLE;
                    if (mem_error) begin
                        fault_n = 1'b1;
                        cause_n = CAUSE_BUS;
                    end else begin
                        instr_n = mem_rdata;
                    end
                end else begin
                    if (count != CNT_MAX) begin
                        count_n = count + CNT_W'(1);
                    end
                    if (TIMEOUT_EN && (count == CNT_LAST)) begin
                        done_n    = 1'b1;
                        fault_n   = 1'b1;
                        cause_n   = CAUSE_TIMEOUT;
                        mem_req_n = 1'b0;
                        state_n   = S_IDLE;
                    end
                end
            end
        endcase
    end

    assign busy = (state == S_WAIT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch: each fetch is planned as a transaction and a
// model predicts every output cycle by cycle from that plan.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;
    logic        busy;
    logic        done;
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  fault_cause;

    always #5 clk = ~clk;

    instruction_fetch #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_error  (mem_error),
        .busy       (busy),
        .done       (done),
        .instr      (instr),
        .fault      (fault),
        .fault_cause(fault_cause)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    // Architectural view the model keeps between transactions.
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic        m_fault;
    logic [1:0]  m_cause;

    logic        exp_req;
    logic        exp_busy;
    logic        exp_done;
    logic [31:0] exp_addr;
    logic [31:0] exp_instr;
    logic        exp_fault;
    logic [1:0]  exp_cause;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
    endtask

    task automatic set_exp(input bit req, input bit bsy, input bit dn);
        exp_req   = req;
        exp_busy  = bsy;
        exp_done  = dn;
        exp_addr  = m_addr;
        exp_instr = m_instr;
        exp_fault = m_fault;
        exp_cause = m_cause;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("mem_req",     32'(mem_req),     32'(exp_req));
            check("mem_addr",    mem_addr,         exp_addr);
            check("busy",        32'(busy),        32'(exp_busy));
            check("done",        32'(done),        32'(exp_done));
            check("instr",       instr,            exp_instr);
            check("fault",       32'(fault),       32'(exp_fault));
            check("fault_cause", 32'(fault_cause), 32'(exp_cause));
        end
    end

    // Idle cycle with bus noise that an idle fetch unit must ignore.
    task automatic idle_cycle();
        start     = 1'b0;
        pc        = $urandom();
        mem_ready = 1'($urandom_range(0, 1));
        mem_error = 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        step();
        set_exp(1'b0, 1'b0, 1'b0);
    endtask

    // One fetch: w idle WAIT cycles before ready; w >= TO means the fetch times out.
    task automatic fetch(input logic [31:0] a, input int w, input bit err,
                         input logic [31:0] rd, input bit noise);
        bit ready_now;
        start     = 1'b1;
        pc        = a;
        mem_ready = 1'($urandom_range(0, 1));
        mem_error = 1'b0;
        step();
        start     = 1'b0;
        mem_ready = 1'b0;
        if (a[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_cause = 2'd1;
            set_exp(1'b0, 1'b0, 1'b1);
            return;
        end
        m_addr  = a;
        m_fault = 1'b0;
        m_cause = 2'd0;
        set_exp(1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= TO; i++) begin
            ready_now = (i == w + 1);
            mem_ready = ready_now;
            mem_error = ready_now ? err : 1'($urandom_range(0, 1));
            mem_rdata = ready_now ? rd : $urandom();
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                pc    = $urandom();
            end
            step();
            start     = 1'b0;
            mem_ready = 1'b0;
            if (ready_now) begin
                if (err) begin
                    m_fault = 1'b1;
                    m_cause = 2'd2;
                end else begin
                    m_instr = rd;
                end
                set_exp(1'b0, 1'b0, 1'b1);
                return;
            end else if (i == TO) begin
                m_fault = 1'b1;
                m_cause = 2'd3;
                set_exp(1'b0, 1'b0, 1'b1);
                return;
            end
            set_exp(1'b1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        reset     = 1'b1;
        start     = 1'b0;
        pc        = '0;
        mem_ready = 1'b0;
        mem_error = 1'b0;
        mem_rdata = '0;

        step();
        m_addr  = '0;
        m_instr = '0;
        m_fault = 1'b0;
        m_cause = 2'd0;
        set_exp(1'b0, 1'b0, 1'b0);
        check_en = 1'b1;
        step();
        set_exp(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) idle_cycle();
        check("lit_reset_req",   32'(mem_req), 32'h0);
        check("lit_reset_instr", instr,        32'h0);

        $display("[TB] aligned fetch, zero wait states");
        fetch(32'h0000_0100, 0, 1'b0, 32'h0051_0113, 1'b0);
        check("lit_ok_done",  32'(done),  32'h1);
        check("lit_ok_addr",  mem_addr,   32'h0000_0100);
        check("lit_ok_instr", instr,      32'h0051_0113);
        check("lit_ok_fault", 32'(fault), 32'h0);
        idle_cycle();

        $display("[TB] misaligned fetch");
        fetch(32'h0000_0202, 0, 1'b0, 32'h0, 1'b0);
        check("lit_mis_done",  32'(done),        32'h1);
        check("lit_mis_cause", 32'(fault_cause), 32'h1);
        check("lit_mis_instr", instr,            32'h0051_0113);
        idle_cycle();

        $display("[TB] bus error after three wait states with stray starts");
        fetch(32'h0000_0400, 3, 1'b1, 32'hDEAD_BEEF, 1'b1);
        check("lit_bus_fault", 32'(fault),       32'h1);
        check("lit_bus_cause", 32'(fault_cause), 32'h2);
        check("lit_bus_instr", instr,            32'h0051_0113);
        idle_cycle();

        $display("[TB] timeout and ready on the boundary cycle");
        fetch(32'h0000_0800, 10, 1'b0, 32'h0, 1'b0);
        check("lit_to_cause", 32'(fault_cause), 32'h3);
        check("lit_to_req",   32'(mem_req),     32'h0);
        fetch(32'h0000_0804, TO - 1, 1'b0, 32'h1234_5678, 1'b0);
        check("lit_edge_cause", 32'(fault_cause), 32'h0);
        check("lit_edge_instr", instr,            32'h1234_5678);

        $display("[TB] reset during the second WAIT cycle");
        start = 1'b1;
        pc    = 32'h0000_0C00;
        step();
        start   = 1'b0;
        m_addr  = 32'h0000_0C00;
        m_fault = 1'b0;
        m_cause = 2'd0;
        set_exp(1'b1, 1'b1, 1'b0);
        step();
        set_exp(1'b1, 1'b1, 1'b0);
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        reset     = 1'b0;
        mem_ready = 1'b0;
        m_addr  = '0;
        m_instr = '0;
        m_fault = 1'b0;
        m_cause = 2'd0;
        set_exp(1'b0, 1'b0, 1'b0);
        check("lit_rst_busy", 32'(busy), 32'h0);
        check("lit_rst_done", 32'(done), 32'h0);
        fetch(32'h0000_1000, 1, 1'b0, 32'hCAFE_F00D, 1'b0);
        check("lit_after_rst_instr", instr, 32'hCAFE_F00D);

        $display("[TB] randomized fetches");
        for (int t = 0; t < 150; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
            a = $urandom();
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            fetch(a, $urandom_range(0, 5), ($urandom_range(0, 3) == 0),
                  $urandom(), 1'($urandom_range(0, 1)));
        end
        repeat (2) idle_cycle();
        check_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
